// File: rtl/mac_unit.sv
// Registered unsigned multiply-accumulate y = a*b + c, one cycle latency, new result every edge.
// No handshake or stall; wraps or saturates on overflow (SATURATE), with a registered overflow flag.
module mac_unit #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int C_W      = 16,
  parameter int Y_W      = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [C_W-1:0] c,
  output logic [Y_W-1:0] y,
  output logic           ovf
);

  localparam int P_W   = A_W + B_W;
  localparam int S_W   = ((P_W > C_W) ? P_W : C_W) + 1;
  localparam int EXT_W = (S_W > Y_W) ? S_W : Y_W;

  logic [P_W-1:0]   w_p;
  logic [S_W-1:0]   w_s;
  logic [EXT_W-1:0] w_s_ext;
  logic [Y_W-1:0]   w_y;
  logic             w_ovf;

  logic [Y_W-1:0]   r_y;
  logic             r_ovf;

  // Operands are widened first so no carry is lost before the overflow test.
  assign w_p     = P_W'(a) * P_W'(b);
  assign w_s     = S_W'(w_p) + S_W'(c);
  assign w_s_ext = EXT_W'(w_s);
  assign w_ovf   = (w_s_ext >> Y_W) != '0;
  assign w_y     = (SATURATE && w_ovf) ? '1 : w_s_ext[Y_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_y   <= w_y;
      r_ovf <= w_ovf;
    end
  end

  assign y   = r_y;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: wrap and saturate instances share stimulus, expected values hand-computed.
module tb_mac_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ia;
  logic [7:0]  ib;
  logic [15:0] ic;
  logic [15:0] y_w;
  logic        ovf_w;
  logic [15:0] y_s;
  logic        ovf_s;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic [15:0] yw;
    logic        ow;
    logic [15:0] ys;
    logic        os;
  } vec_t;

  vec_t vecs[9];

  mac_unit #(.A_W(8), .B_W(8), .C_W(16), .Y_W(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .a(ia), .b(ib), .c(ic), .y(y_w), .ovf(ovf_w)
  );

  mac_unit #(.A_W(8), .B_W(8), .C_W(16), .Y_W(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(ia), .b(ib), .c(ic), .y(y_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] eyw, input logic eow,
                         input logic [15:0] eys, input logic eos);
    chk({name, ".y_wrap"},   32'(y_w),   32'(eyw));
    chk({name, ".ovf_wrap"}, 32'(ovf_w), 32'(eow));
    chk({name, ".y_sat"},    32'(y_s),   32'(eys));
    chk({name, ".ovf_sat"},  32'(ovf_s), 32'(eos));
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    @(negedge clk);
    ia = a;
    ib = b;
    ic = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //        a    b    c      y_wrap ovf  y_sat  ovf
    vecs[0] = '{8'd3,   8'd4,   16'd5,     16'd17,    1'b0, 16'd17,    1'b0};
    vecs[1] = '{8'd10,  8'd2,   16'd7,     16'd27,    1'b0, 16'd27,    1'b0};
    vecs[2] = '{8'd255, 8'd255, 16'd65535, 16'd65024, 1'b1, 16'd65535, 1'b1};
    vecs[3] = '{8'd0,   8'd0,   16'd0,     16'd0,     1'b0, 16'd0,     1'b0};
    vecs[4] = '{8'd255, 8'd1,   16'd65280, 16'd65535, 1'b0, 16'd65535, 1'b0};
    vecs[5] = '{8'd255, 8'd255, 16'd0,     16'd65025, 1'b0, 16'd65025, 1'b0};
    vecs[6] = '{8'd0,   8'd0,   16'd65535, 16'd65535, 1'b0, 16'd65535, 1'b0};
    vecs[7] = '{8'd255, 8'd255, 16'd511,   16'd0,     1'b1, 16'd65535, 1'b1};
    vecs[8] = '{8'd200, 8'd100, 16'd50000, 16'd4464,  1'b1, 16'd65535, 1'b1};

    rst_n = 1'b0;
    ia = 8'd3;
    ib = 8'd4;
    ic = 16'd5;
    #1;
    chk_all("rst_t0", 16'd0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all("rst_hold", 16'd0, 1'b0, 16'd0, 1'b0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("first_edge", 16'd17, 1'b0, 16'd17, 1'b0);

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].yw, vecs[i].ow, vecs[i].ys, vecs[i].os);
    end

    // Mid-cycle input change must not reach y before the next edge.
    apply(8'd10, 8'd2, 16'd7);
    chk_all("lat_pre", 16'd27, 1'b0, 16'd27, 1'b0);
    #3;
    ia = 8'd3;
    ib = 8'd4;
    ic = 16'd5;
    #2;
    chk_all("lat_hold", 16'd27, 1'b0, 16'd27, 1'b0);
    @(posedge clk);
    #1;
    chk_all("lat_next", 16'd17, 1'b0, 16'd17, 1'b0);

    apply(8'd10, 8'd2, 16'd7);
    chk_all("arst_pre", 16'd27, 1'b0, 16'd27, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("arst_async", 16'd0, 1'b0, 16'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("arst_edge", 16'd0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ia = 8'd255;
    ib = 8'd255;
    ic = 16'd65535;
    @(posedge clk);
    #1;
    chk_all("arst_release", 16'd65024, 1'b1, 16'd65535, 1'b1);

    // Reset while ovf is high, then confirm no stale result returns.
    @(negedge clk);
    rst_n = 1'b0;
    ia = 8'd3;
    ib = 8'd4;
    ic = 16'd5;
    #1;
    chk_all("arst_ovf", 16'd0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("arst_ovf_release", 16'd17, 1'b0, 16'd17, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
